// File: rtl/cam_arbiter.sv
// cam_arbiter: two-requester front end for a single-port CAM.
//
// Requesters 0 and 1 issue either a write (store data at addr) or a search
// (look up data as a key). One command is serviced at a time:
//   IDLE  -> pick a requester, accept its command
//   ISSUE -> one-cycle CAM strobe with the latched command
//   WAIT  -> CAM_LAT cycles for the CAM result
//   RESP  -> hold the response until the owning requester takes it
//
// Handshake semantics (all four channels): a transfer happens on a rising
// clk edge where valid and ready are both 1. A producer holds valid and its
// payload unchanged until that edge. reqN_ready depends combinationally on
// reqN_valid; rspN_valid never depends on rspN_ready.
//
// Optional feature macro: CAM_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin tie break between the two requesters
//   undefined -> fixed priority, requester 0 wins every tie
module cam_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int CAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp0_found,
  output logic [ADDR_W-1:0] rsp0_addr,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic              rsp1_found,
  output logic [ADDR_W-1:0] rsp1_addr,
  output logic              cam_req,
  output logic              cam_write,
  output logic [ADDR_W-1:0] cam_addr,
  output logic [DATA_W-1:0] cam_data,
  input  logic              cam_found,
  input  logic [ADDR_W-1:0] cam_match_addr,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter value on the last WAIT cycle; the CAM result is valid then.
  localparam logic [2:0] LAST_CNT = 3'(CAM_LAT - 1);

  state_t              state_q;
  state_t              state_d;

  // Latched command and owner of the command in flight.
  logic                grant_q;
  logic                cmd_write_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_data_q;

  logic [2:0]          wait_cnt_q;
  logic                wait_done;

  // Response payload captured at the end of WAIT.
  logic                rsp_found_q;
  logic [ADDR_W-1:0]   rsp_addr_q;

  logic                grant_sel;   // requester chosen this cycle (0 or 1)
  logic                accept;      // a command is taken on the next edge
  logic                rsp_take;    // owning requester takes the response

`ifdef CAM_ARB_ROUND_ROBIN_EN
  // Requester that wins the next tie; flips to the other one on each accept.
  logic                prio_q;
`endif

  // Requester selection: only meaningful when at least one valid is high.
  always_comb begin
    grant_sel = 1'b0;
`ifdef CAM_ARB_ROUND_ROBIN_EN
    if (req0_valid && req1_valid) begin
      grant_sel = prio_q;
    end else begin
      grant_sel = req1_valid;
    end
`else
    grant_sel = !req0_valid;
`endif
  end

  // Ready is offered only in IDLE, only to the selected requester, and never
  // while reset is asserted (the state register is already IDLE then).
  always_comb begin
    accept     = (state_q == IDLE) && rst_n && (req0_valid || req1_valid);
    req0_ready = accept && !grant_sel;
    req1_ready = accept &&  grant_sel;
  end

  assign wait_done = (wait_cnt_q == LAST_CNT);
  assign rsp_take  = grant_q ? rsp1_ready : rsp0_ready;

  // Next-state logic for the command sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept)    state_d = ISSUE;
      ISSUE:                state_d = WAIT;
      WAIT:  if (wait_done) state_d = RESP;
      RESP:  if (rsp_take)  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch: captured on the accepting edge, held until the next one,
  // which also keeps cam_addr/cam_data steady outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
    end else if (accept) begin
      grant_q <= grant_sel;
      if (grant_sel) begin
        cmd_write_q <= req1_write;
        cmd_addr_q  <= req1_addr;
        cmd_data_q  <= req1_data;
      end else begin
        cmd_write_q <= req0_write;
        cmd_addr_q  <= req0_addr;
        cmd_data_q  <= req0_data;
      end
    end
  end

  // WAIT counter: counts up through WAIT, rests at zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 3'd0;
    end else if ((state_q == WAIT) && !wait_done) begin
      wait_cnt_q <= wait_cnt_q + 3'd1;
    end else begin
      wait_cnt_q <= 3'd0;
    end
  end

  // Response capture on the last WAIT cycle; writes echo their own address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_found_q <= 1'b0;
      rsp_addr_q  <= '0;
    end else if ((state_q == WAIT) && wait_done) begin
      if (cmd_write_q) begin
        rsp_found_q <= 1'b0;
        rsp_addr_q  <= cmd_addr_q;
      end else begin
        rsp_found_q <= cam_found;
        rsp_addr_q  <= cam_match_addr;
      end
    end
  end

`ifdef CAM_ARB_ROUND_ROBIN_EN
  // Tie-break pointer: after serving a requester, the other one wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (accept) begin
      prio_q <= !grant_sel;
    end
  end
`endif

  // CAM side: strobe and write enable only in ISSUE; address/data follow
  // the latched command.
  always_comb begin
    cam_req   = (state_q == ISSUE);
    cam_write = (state_q == ISSUE) && cmd_write_q;
    cam_addr  = cmd_addr_q;
    cam_data  = cmd_data_q;
    busy      = (state_q != IDLE);
  end

  // Response side: only the owner sees valid; payload is zero when not valid.
  always_comb begin
    rsp0_valid = (state_q == RESP) && !grant_q;
    rsp1_valid = (state_q == RESP) &&  grant_q;
    rsp0_found = rsp0_valid ? rsp_found_q : 1'b0;
    rsp0_addr  = rsp0_valid ? rsp_addr_q  : '0;
    rsp1_found = rsp1_valid ? rsp_found_q : 1'b0;
    rsp1_addr  = rsp1_valid ? rsp_addr_q  : '0;
  end

endmodule

// File: tb/tb_cam_arbiter.sv
// tb_cam_arbiter: self-checking bench for cam_arbiter.
// Main DUT uses CAM_LAT=1 and is checked every cycle against a transaction
// model plus directed literal checks; a second DUT with CAM_LAT=7 gets a
// directed latency / glitch test. Build with +define+CAM_ARB_ROUND_ROBIN_EN
// to check the round-robin variant.
module tb_cam_arbiter;

  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int LAT = 1;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic          req0_valid, req0_ready, req0_write;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid, req1_ready, req1_write;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          rsp0_valid, rsp0_ready, rsp0_found;
  logic [AW-1:0] rsp0_addr;
  logic          rsp1_valid, rsp1_ready, rsp1_found;
  logic [AW-1:0] rsp1_addr;
  logic          cam_req, cam_write, cam_found, busy;
  logic [AW-1:0] cam_addr, cam_match_addr;
  logic [DW-1:0] cam_data;

  cam_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CAM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_found(rsp0_found),
    .rsp0_addr(rsp0_addr),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_found(rsp1_found),
    .rsp1_addr(rsp1_addr),
    .cam_req(cam_req), .cam_write(cam_write), .cam_addr(cam_addr),
    .cam_data(cam_data), .cam_found(cam_found), .cam_match_addr(cam_match_addr),
    .busy(busy)
  );

  // ---------------- CAM_LAT=7 DUT signals ----------------
  logic          d7_req0_valid, d7_req0_ready, d7_req0_write;
  logic [AW-1:0] d7_req0_addr;
  logic [DW-1:0] d7_req0_data;
  logic          d7_req1_valid, d7_req1_ready, d7_req1_write;
  logic [AW-1:0] d7_req1_addr;
  logic [DW-1:0] d7_req1_data;
  logic          d7_rsp0_valid, d7_rsp0_ready, d7_rsp0_found;
  logic [AW-1:0] d7_rsp0_addr;
  logic          d7_rsp1_valid, d7_rsp1_ready, d7_rsp1_found;
  logic [AW-1:0] d7_rsp1_addr;
  logic          d7_cam_req, d7_cam_write, d7_cam_found, d7_busy;
  logic [AW-1:0] d7_cam_addr, d7_cam_match_addr;
  logic [DW-1:0] d7_cam_data;

  cam_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CAM_LAT(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(d7_req0_valid), .req0_ready(d7_req0_ready), .req0_write(d7_req0_write),
    .req0_addr(d7_req0_addr), .req0_data(d7_req0_data),
    .req1_valid(d7_req1_valid), .req1_ready(d7_req1_ready), .req1_write(d7_req1_write),
    .req1_addr(d7_req1_addr), .req1_data(d7_req1_data),
    .rsp0_valid(d7_rsp0_valid), .rsp0_ready(d7_rsp0_ready), .rsp0_found(d7_rsp0_found),
    .rsp0_addr(d7_rsp0_addr),
    .rsp1_valid(d7_rsp1_valid), .rsp1_ready(d7_rsp1_ready), .rsp1_found(d7_rsp1_found),
    .rsp1_addr(d7_rsp1_addr),
    .cam_req(d7_cam_req), .cam_write(d7_cam_write), .cam_addr(d7_cam_addr),
    .cam_data(d7_cam_data), .cam_found(d7_cam_found), .cam_match_addr(d7_cam_match_addr),
    .busy(d7_busy)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req0_ready"}, 32'(req0_ready), 0);
    chk({tag, "_req1_ready"}, 32'(req1_ready), 0);
    chk({tag, "_rsp0_valid"}, 32'(rsp0_valid), 0);
    chk({tag, "_rsp1_valid"}, 32'(rsp1_valid), 0);
    chk({tag, "_rsp0_found"}, 32'(rsp0_found), 0);
    chk({tag, "_rsp1_found"}, 32'(rsp1_found), 0);
    chk({tag, "_rsp0_addr"},  32'(rsp0_addr), 0);
    chk({tag, "_rsp1_addr"},  32'(rsp1_addr), 0);
    chk({tag, "_cam_req"},    32'(cam_req), 0);
    chk({tag, "_cam_write"},  32'(cam_write), 0);
    chk({tag, "_cam_addr"},   32'(cam_addr), 0);
    chk({tag, "_cam_data"},   32'(cam_data), 0);
    chk({tag, "_busy"},       32'(busy), 0);
    chk({tag, "_d7_busy"},    32'(d7_busy), 0);
  endtask

  // ---------------- behavioural model state ----------------
  cmd_t          q0[$];
  cmd_t          q1[$];
  int            grant_log[$];
  bit            drv_en = 0;
  bit            gap_en = 0;
  int            rsp_mode = 0;       // 0 manual, 1 always ready, 2 random
  bit            acc0 = 0, acc1 = 0;

  bit            in_flight = 0;      // a command has been accepted, no rsp taken yet
  int            age = 0;            // cycles since the accepting cycle
  bit            g = 0;              // owner of the command in flight
  cmd_t          cur;
  bit            prio = 0;           // requester winning a tie
  logic          exp_found;
  logic [AW-1:0] exp_raddr;
  logic [AW-1:0] last_a = '0;        // last command shown on the CAM port
  logic [DW-1:0] last_d = '0;
  bit            e0, e1, issue_now;

  // External CAM model: contents persist across arbiter resets.
  logic [DW-1:0] mem[32];
  bit            mval[32];
  bit            pend = 0;
  int            cd = 0;
  logic          res_found;
  logic [AW-1:0] res_addr;

  // Lowest matching address wins.
  function automatic void cam_lookup(input logic [DW-1:0] key, output logic f,
                                     output logic [AW-1:0] a);
    f = 1'b0;
    a = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mval[i] && mem[i] == key) begin
        f = 1'b1;
        a = AW'(i);
      end
    end
  endfunction

  // Per-cycle compare against the transaction model, plus the CAM responder.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight = 0; prio = 0; pend = 0; last_a = '0; last_d = '0;
      acc0 = 0; acc1 = 0;
      cam_found = 1'($urandom_range(0, 1));
      cam_match_addr = AW'($urandom_range(0, 31));
    end else begin
      issue_now = 0;
      if (!in_flight) begin
        e0 = req0_valid && (!req1_valid || !prio);
        e1 = req1_valid && (!req0_valid ||  prio);
        chk("m_ready0", 32'(req0_ready), 32'(e0));
        chk("m_ready1", 32'(req1_ready), 32'(e1));
        chk("m_idle_busy", 32'(busy), 0);
        chk("m_idle_cam_req", 32'(cam_req), 0);
        chk("m_idle_cam_write", 32'(cam_write), 0);
        chk("m_idle_rsp0_valid", 32'(rsp0_valid), 0);
        chk("m_idle_rsp1_valid", 32'(rsp1_valid), 0);
        if (e0 || e1) begin
          in_flight = 1; age = 0; g = e1;
          cur = e1 ? {req1_write, req1_addr, req1_data} : {req0_write, req0_addr, req0_data};
          grant_log.push_back(int'(g));
          if (drv_en) begin
            if (e1) acc1 = 1; else acc0 = 1;
          end
`ifdef CAM_ARB_ROUND_ROBIN_EN
          prio = !g;
`endif
        end
      end else begin
        age++;
        if (age == 1) begin
          last_a = cur.a; last_d = cur.d;
          if (cur.w) begin
            mem[cur.a] = cur.d; mval[cur.a] = 1;
            exp_found = 1'b0; exp_raddr = cur.a;
            res_found = 1'($urandom_range(0, 1));
            res_addr  = AW'($urandom_range(0, 31));
          end else begin
            cam_lookup(cur.d, exp_found, exp_raddr);
            res_found = exp_found; res_addr = exp_raddr;
          end
          issue_now = 1;
        end
        chk("m_busy_ready0", 32'(req0_ready), 0);
        chk("m_busy_ready1", 32'(req1_ready), 0);
        chk("m_busy", 32'(busy), 1);
        chk("m_cam_req", 32'(cam_req), 32'(age == 1));
        chk("m_cam_write", 32'(cam_write), 32'(age == 1 && cur.w));
        if (age >= LAT + 2) begin
          chk("m_rsp_valid_own", 32'(g ? rsp1_valid : rsp0_valid), 1);
          chk("m_rsp_valid_other", 32'(g ? rsp0_valid : rsp1_valid), 0);
          chk("m_rsp_found", 32'(g ? rsp1_found : rsp0_found), 32'(exp_found));
          chk("m_rsp_addr", 32'(g ? rsp1_addr : rsp0_addr), 32'(exp_raddr));
          if (g ? rsp1_ready : rsp0_ready) in_flight = 0;
        end else begin
          chk("m_early_rsp0_valid", 32'(rsp0_valid), 0);
          chk("m_early_rsp1_valid", 32'(rsp1_valid), 0);
        end
      end
      chk("m_cam_addr", 32'(cam_addr), 32'(last_a));
      chk("m_cam_data", 32'(cam_data), 32'(last_d));
      // CAM outputs: the real result only in the cycle the arbiter samples.
      if (pend) cd--;
      if (pend && cd == 0) begin
        cam_found = res_found; cam_match_addr = res_addr; pend = 0;
      end else begin
        cam_found = 1'($urandom_range(0, 1));
        cam_match_addr = AW'($urandom_range(0, 31));
      end
      if (issue_now) begin
        pend = 1; cd = LAT;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int n);
    cmd_t c;
    int   gap;
    bit   have;
    gap = 0;
    forever begin
      @(posedge clk); #1;
      if (drv_en) begin
        if (n == 0 && acc0) begin
          acc0 = 0; void'(q0.pop_front());
          gap = gap_en ? $urandom_range(0, 3) : 0;
        end
        if (n == 1 && acc1) begin
          acc1 = 0; void'(q1.pop_front());
          gap = gap_en ? $urandom_range(0, 3) : 0;
        end
        have = 0;
        if (gap > 0) begin
          gap--;
        end else if (n == 0 && q0.size() > 0) begin
          c = q0[0]; have = 1;
        end else if (n == 1 && q1.size() > 0) begin
          c = q1[0]; have = 1;
        end
        if (n == 0) begin
          req0_valid = have;
          if (have) begin req0_write = c.w; req0_addr = c.a; req0_data = c.d; end
        end else begin
          req1_valid = have;
          if (have) begin req1_write = c.w; req1_addr = c.a; req1_data = c.d; end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rsp_mode == 1) begin
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    end else if (rsp_mode == 2) begin
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while ((q0.size() != 0 || q1.size() != 0 || in_flight) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL %s_timeout: waited %0d cycles, q0=%0d q1=%0d in_flight=%0d",
               tag, k, q0.size(), q1.size(), in_flight);
    end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.w = 1'($urandom_range(0, 1));
    c.a = AW'($urandom_range(0, 31));
    c.d = DW'($urandom_range(0, 7));
    return c;
  endfunction

  initial begin
    fork
      drive_req(0);
      drive_req(1);
    join_none
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    req0_valid = 1; req0_write = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 1; req1_write = 0; req1_addr = '0; req1_data = '0;
    rsp0_ready = 0; rsp1_ready = 0;
    d7_req0_valid = 0; d7_req0_write = 0; d7_req0_addr = '0; d7_req0_data = '0;
    d7_req1_valid = 0; d7_req1_write = 0; d7_req1_addr = '0; d7_req1_data = '0;
    d7_rsp0_ready = 0; d7_rsp1_ready = 0;
    d7_cam_found = 0; d7_cam_match_addr = '0;
    cam_found = 0; cam_match_addr = '0;

    // Reset: every output zero even with both requests raised.
    #2;
    chk_zero("rst0");
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Write from req0 (addr 5, data A3), then stall its response 5 cycles.
    tick();
    req0_valid = 1; req0_write = 1; req0_addr = 5'd5; req0_data = 8'hA3;
    @(negedge clk); chk("w_accept_ready0", 32'(req0_ready), 1);
    tick(); req0_valid = 0;
    @(negedge clk);
    chk("w_cam_req", 32'(cam_req), 1);
    chk("w_cam_write", 32'(cam_write), 1);
    chk("w_cam_addr", 32'(cam_addr), 5);
    chk("w_cam_data", 32'(cam_data), 32'hA3);
    tick(); @(negedge clk); chk("w_t2_rsp0_valid", 32'(rsp0_valid), 0);
    tick();
    req1_valid = 1; req1_write = 0; req1_addr = 5'd0; req1_data = 8'hA3;
    @(negedge clk);
    chk("w_t3_rsp0_valid", 32'(rsp0_valid), 1);
    chk("w_t3_rsp0_found", 32'(rsp0_found), 0);
    chk("w_t3_rsp0_addr", 32'(rsp0_addr), 5);
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk);
      chk("stall_rsp0_valid", 32'(rsp0_valid), 1);
      chk("stall_rsp0_addr", 32'(rsp0_addr), 5);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_req1_ready", 32'(req1_ready), 0);
    end
    tick(); rsp0_ready = 1;
    @(negedge clk); chk("take_rsp0_valid", 32'(rsp0_valid), 1);
    tick(); rsp0_ready = 0;
    @(negedge clk);
    chk("after_take_busy", 32'(busy), 0);
    chk("after_take_req1_ready", 32'(req1_ready), 1);

    // Search from req1 for A3: CAM reports hit at 5.
    tick(); req1_valid = 0;
    @(negedge clk);
    chk("s_cam_req", 32'(cam_req), 1);
    chk("s_cam_write", 32'(cam_write), 0);
    chk("s_cam_data", 32'(cam_data), 32'hA3);
    tick(); @(negedge clk);
    tick(); @(negedge clk);
    chk("s_rsp1_valid", 32'(rsp1_valid), 1);
    chk("s_rsp1_found", 32'(rsp1_found), 1);
    chk("s_rsp1_addr", 32'(rsp1_addr), 5);
    chk("s_rsp0_valid", 32'(rsp0_valid), 0);
    tick(); rsp1_ready = 1;
    tick(); rsp1_ready = 0;
    @(negedge clk); chk("s_done_busy", 32'(busy), 0);

    // Reset in WAIT: command aborted, fresh request accepted right after.
    tick();
    req0_valid = 1; req0_write = 0; req0_data = 8'h3C;
    @(negedge clk);
    tick(); req0_valid = 0;
    req1_valid = 1; req1_write = 1; req1_addr = 5'd9; req1_data = 8'h11;
    @(negedge clk);
    tick(); @(negedge clk);
    #1;
    do_reset("rst_wait");
    @(negedge clk);
    chk("post_rst_req1_ready", 32'(req1_ready), 1);
    tick(); req1_valid = 0;
    @(negedge clk);
    chk("post_rst_cam_req", 32'(cam_req), 1);
    chk("post_rst_cam_addr", 32'(cam_addr), 9);
    rsp_mode = 1;
    repeat (4) @(negedge clk);
    rsp_mode = 0;
    tick(); rsp0_ready = 0; rsp1_ready = 0;

    // Arbitration order: 4 commands per requester, both pending together.
    do_reset("rst_arb");
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rand_cmd());
      q1.push_back(rand_cmd());
    end
    grant_log.delete();
    rsp_mode = 1; gap_en = 0;
    @(negedge clk); drv_en = 1;
    wait_drain("arb", 200);
    drv_en = 0;
    chk("arb_grant_count", 32'(grant_log.size()), 8);
    for (int i = 0; i < 8; i++) begin
      int gv;
      int ev;
      gv = (i < grant_log.size()) ? grant_log[i] : 9;
`ifdef CAM_ARB_ROUND_ROBIN_EN
      ev = i % 2;
`else
      ev = (i >= 4) ? 1 : 0;
`endif
      chk($sformatf("arb_grant%0d", i), 32'(gv), 32'(ev));
    end

    // Randomized traffic with gaps and random response back-pressure.
    for (int i = 0; i < 80; i++) begin
      q0.push_back(rand_cmd());
      q1.push_back(rand_cmd());
    end
    rsp_mode = 2; gap_en = 1;
    @(negedge clk); drv_en = 1;
    wait_drain("rand", 6000);
    drv_en = 0; rsp_mode = 0;
    tick(); rsp0_ready = 0; rsp1_ready = 0; req0_valid = 0; req1_valid = 0;

    // CAM_LAT=7: response exactly 9 cycles after accept, glitches ignored.
    tick();
    d7_req0_valid = 1; d7_req0_write = 0; d7_req0_data = 8'h42;
    @(negedge clk); chk("l7_ready0", 32'(d7_req0_ready), 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) d7_req0_valid = 0;
      @(negedge clk);
      chk($sformatf("l7_cam_req_k%0d", k), 32'(d7_cam_req), 32'(k == 1));
      chk($sformatf("l7_rsp_valid_k%0d", k), 32'(d7_rsp0_valid), 32'(k >= 9));
      if (k >= 9) begin
        chk($sformatf("l7_found_k%0d", k), 32'(d7_rsp0_found), 0);
        chk($sformatf("l7_addr_k%0d", k), 32'(d7_rsp0_addr), 12);
      end
      if (k == 8) begin
        d7_cam_found = 0; d7_cam_match_addr = 5'd12;
      end else begin
        d7_cam_found = 1; d7_cam_match_addr = 5'd3;
      end
    end
    tick(); d7_rsp0_ready = 1;
    @(negedge clk); chk("l7_take_valid", 32'(d7_rsp0_valid), 1);
    tick(); d7_rsp0_ready = 0;
    @(negedge clk); chk("l7_done_busy", 32'(d7_busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cam_arbiter.md
CAM_ARBITER -- requirements
Module: cam_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: CAM address width.
REQ-002 SHALL have parameter DATA_W, default 8: CAM data/key width.
REQ-003 SHALL have parameter CAM_LAT, default 1, legal 1..7: cycles from cam_req to a valid cam_found/cam_match_addr.
REQ-004 SHALL have the following ports; clock and reset first:
 clk  in  1  single clock, rising edge
 rst_n  in  1  asynchronous reset, active low
 reqN_valid  in  1  requester N (N=0,1) has a command
 reqN_ready  out  1  command from N accepted this cycle
 reqN_write  in  1  1=write reqN_data at reqN_addr, 0=search for reqN_data
 reqN_addr  in  ADDR_W  write address (ignored on search)
 reqN_data  in  DATA_W  write data or search key
 rspN_valid  out  1  response to N pending
 rspN_ready  in  1  requester N takes the response
 rspN_found  out  1  search hit (0 for writes)
 rspN_addr  out  ADDR_W  matching address (search) or echoed address (write)
 cam_req  out  1  one-cycle CAM access strobe
 cam_write  out  1  CAM write enable, qualified by cam_req
 cam_addr  out  ADDR_W  CAM address
 cam_data  out  DATA_W  CAM write data / search key
 cam_found  in  1  CAM hit flag
 cam_match_addr  in  ADDR_W  CAM match address
 busy  out  1  high in every state except IDLE

Function
REQ-005 SHALL implement states IDLE, ISSUE, WAIT and RESP, and SHALL service one command at a time.
REQ-006 In IDLE, SHALL select one requester with reqN_valid=1 and drive reqN_ready=1 combinationally for that requester only; the other reqN_ready SHALL be 0.
REQ-007 On the edge where valid&ready=1, SHALL latch write/addr/data and the grant index, then go to ISSUE.
REQ-008 In ISSUE (exactly one cycle), SHALL drive cam_req=1, cam_write=latched write, cam_addr=latched addr and cam_data=latched data, then go to WAIT.
REQ-009 Outside ISSUE, SHALL hold cam_req=0 and cam_write=0; cam_addr and cam_data SHALL retain their last values.
REQ-010 In WAIT, SHALL count CAM_LAT cycles with a 3-bit counter, then sample cam_found and cam_match_addr and go to RESP.
REQ-011 For a search, SHALL set rspN_found=sampled cam_found and rspN_addr=sampled cam_match_addr.
REQ-012 For a write, SHALL set rspN_found=0 and rspN_addr=latched addr.
REQ-013 Accept at cycle T SHALL give cam_req at T+1 and rspN_valid from T+2+CAM_LAT; with CAM_LAT=1 rspN_valid SHALL rise at T+3.
REQ-014 In RESP, SHALL hold rspN_valid and its payload stable until rspN_ready=1, then return to IDLE on that edge; only the granted requester's rspN_valid SHALL go high.
REQ-015 SHALL assert no reqN_ready outside IDLE; requests raised while busy SHALL wait unchanged.
REQ-016 With both reqN_valid=1 in IDLE, SHALL grant according to the REQ-020 policy.
REQ-017 rspN_ready while rspN_valid=0 SHALL be ignored.

Reset
REQ-018 When rst_n=0, SHALL enter IDLE immediately (asynchronously) and abort any command in flight without issuing a response.
REQ-019 During reset, SHALL drive every output 0: reqN_ready, rspN_valid, rspN_found, rspN_addr, cam_req, cam_write, cam_addr, cam_data and busy; the WAIT counter SHALL be 0 and the priority pointer SHALL point at requester 0.

Configuration
REQ-020 With macro CAM_ARB_ROUND_ROBIN_EN defined, SHALL use round-robin: on a tie, grant the requester not served last, with the pointer updated on each accept. Without the macro, SHALL use fixed priority, requester 0 always winning ties.

Verification
REQ-021 Req0 write addr=5 data=0xA3, CAM_LAT=1, accept at T -> cam_req=1, cam_write=1, cam_addr=5, cam_data=0xA3 at T+1; rsp0_valid=1, found=0, addr=5 at T+3.
REQ-022 Req1 search 0xA3, CAM returns found=1, match=5 -> rsp1_valid=1, rsp1_found=1, rsp1_addr=5; rsp0_valid stays 0.
REQ-023 Both valid for 4 commands each, rsp ready=1 -> with CAM_ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1...; without it all of req0 are served before req1.
REQ-024 rsp0_ready held 0 for 5 cycles in RESP -> rsp0_valid and payload stable, busy=1, req1_ready=0; rsp0_ready=1 -> next cycle IDLE.
REQ-025 rst_n pulsed low during WAIT -> all outputs 0 immediately, no response issued; a new request is accepted in the first cycle after reset release.
REQ-026 CAM_LAT=7 search -> rsp_valid rises exactly 9 cycles after accept; a cam_found glitch before the sample cycle has no effect.
